mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle between the requester ports, the arbiter and the shared downstream
// memory. The arbiter uses the slave modport. The requesters and memory model
// use the master modport.
interface mem_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128
);
  // Requester side.
  logic [N_PORTS-1:0]        read;
  logic [N_PORTS-1:0]        write;
  logic [N_PORTS*ADDR_W-1:0] address;
  logic [N_PORTS*DATA_W-1:0] writedata;
  logic [N_PORTS*DATA_W-1:0] readdata;
  logic [N_PORTS-1:0]        busywait;

  // Downstream memory side.
  logic                      mem_read;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_address;
  logic [DATA_W-1:0]         mem_writedata;
  logic [DATA_W-1:0]         mem_readdata;
  logic                      mem_busywait;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-oriented memory among N_PORTS cache-side
// requesters. It runs one transaction at a time through the states
// IDLE -> ISSUE -> WAIT -> DONE.
// Winner selection is round-robin by default.
// Defining ARB_FIXED_PRIORITY_EN changes the selection so that the
// lowest-indexed pending port always wins.
module mem_arbiter #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_r;
  logic [IDX_W-1:0]          winner_r;
  logic                      mem_read_r;
  logic                      mem_write_r;
  logic [ADDR_W-1:0]         mem_address_r;
  logic [DATA_W-1:0]         mem_writedata_r;
  logic [N_PORTS*DATA_W-1:0] readdata_r;
`ifndef ARB_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]          last_grant_r;
`endif

  logic [N_PORTS-1:0]        pending_s;
  logic [N_PORTS-1:0]        busywait_s;
  logic                      grant_found_s;
  logic [IDX_W-1:0]          grant_idx_s;
  logic [IDX_W:0]            cand_s;

  assign pending_s = bus.read | bus.write;

  // Winner search: rotating start after last_grant, or fixed lowest-index first.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IDX_W{1'b0}};
    cand_s        = {(IDX_W+1){1'b0}};
    for (int k = 0; k < N_PORTS; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      cand_s = (IDX_W+1)'(k);
`else
      cand_s = {1'b0, last_grant_r} + (IDX_W+1)'(k + 32'sd1);
      if (cand_s >= (IDX_W+1)'(N_PORTS)) begin
        cand_s = cand_s - (IDX_W+1)'(N_PORTS);
      end else begin
        cand_s = cand_s;
      end
`endif
      if (!grant_found_s && pending_s[cand_s[IDX_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[IDX_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Each requester stalls while pending, except in its own DONE cycle.
  always_comb begin
    busywait_s = pending_s;
    if (state_r == DONE) begin
      busywait_s[winner_r] = 1'b0;
    end else begin
      busywait_s = pending_s;
    end
  end

  // Transaction FSM. It latches the request once, holds the downstream
  // request until memory releases it, and captures read data for the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      winner_r        <= {IDX_W{1'b0}};
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_address_r   <= {ADDR_W{1'b0}};
      mem_writedata_r <= {DATA_W{1'b0}};
      readdata_r      <= {(N_PORTS*DATA_W){1'b0}};
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant_r    <= IDX_W'(N_PORTS - 1);
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            winner_r        <= grant_idx_s;
            mem_address_r   <= bus.address[grant_idx_s*ADDR_W +: ADDR_W];
            mem_writedata_r <= bus.writedata[grant_idx_s*DATA_W +: DATA_W];
            // A write request takes precedence when both request bits are high.
            mem_write_r     <= bus.write[grant_idx_s];
            mem_read_r      <= ~bus.write[grant_idx_s];
            state_r         <= ISSUE;
          end else begin
            state_r         <= IDLE;
          end
        end
        ISSUE: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (!bus.mem_busywait) begin
            if (mem_read_r) begin
              readdata_r[winner_r*DATA_W +: DATA_W] <= bus.mem_readdata;
            end else begin
              readdata_r <= readdata_r;
            end
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            state_r     <= DONE;
          end else begin
            state_r     <= WAIT;
          end
        end
        DONE: begin
`ifndef ARB_FIXED_PRIORITY_EN
          last_grant_r <= winner_r;
`endif
          state_r      <= IDLE;
        end
        default: begin
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.busywait      = busywait_s;
  assign bus.readdata      = readdata_r;
  assign bus.mem_read      = mem_read_r;
  assign bus.mem_write     = mem_write_r;
  assign bus.mem_address   = mem_address_r;
  assign bus.mem_writedata = mem_writedata_r;

endmodule
